// File: rtl/regfile_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | regfile_sequencer: round-robin command sequencer for the 8x8 reg file.   |
// | Optional power-up scrub state enabled by REGSEQ_SCRUB_EN.  Rev 1.0       |
// +--------------------------------------------------------------------------+
module regfile_sequencer (
  input  logic       clk,
  input  logic       reset,
  input  logic       c0_req,
  input  logic [1:0] c0_op,
  input  logic [2:0] c0_rd,
  input  logic [2:0] c0_rs,
  input  logic [7:0] c0_data,
  output logic       c0_ack,
  input  logic       c1_req,
  input  logic [1:0] c1_op,
  input  logic [2:0] c1_rd,
  input  logic [2:0] c1_rs,
  input  logic [7:0] c1_data,
  output logic       c1_ack,
  output logic       rf_load,
  output logic [2:0] rf_addr_a,
  output logic [2:0] rf_addr_b,
  output logic       rf_mb_select,
  output logic [7:0] rf_d_in,
  output logic       rf_reset_all,
  input  logic [7:0] rf_val_a,
  input  logic [7:0] rf_val_b,
  output logic       busy
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_EXEC    = 3'd1,
    ST_SW_READ = 3'd2,
    ST_SW_WR_A = 3'd3,
    ST_SW_WR_B = 3'd4
`ifdef REGSEQ_SCRUB_EN
    ,
    ST_INIT    = 3'd5
`endif
  } state_t;

  localparam logic [1:0] OP_WRITE = 2'b00;
  localparam logic [1:0] OP_CLEAR = 2'b01;
  localparam logic [1:0] OP_COPY  = 2'b10;
  localparam logic [1:0] OP_SWAP  = 2'b11;

`ifdef REGSEQ_SCRUB_EN
  localparam state_t RESET_STATE = ST_INIT;
`else
  localparam state_t RESET_STATE = ST_IDLE;
`endif

  state_t     state_q, state_d;
  logic [1:0] op_q, op_d;
  logic [2:0] rd_q, rd_d;
  logic [2:0] rs_q, rs_d;
  logic [7:0] data_q, data_d;
  logic       gnt_q, gnt_d;
  logic       last_q, last_d;
  logic [7:0] tmp_a_q, tmp_a_d;
  logic [7:0] tmp_b_q, tmp_b_d;
  logic       win;
  logic       ack;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RESET_STATE;
      op_q    <= 2'b00;
      rd_q    <= 3'd0;
      rs_q    <= 3'd0;
      data_q  <= 8'h00;
      gnt_q   <= 1'b0;
      last_q  <= 1'b1;
      tmp_a_q <= 8'h00;
      tmp_b_q <= 8'h00;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      rd_q    <= rd_d;
      rs_q    <= rs_d;
      data_q  <= data_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      tmp_a_q <= tmp_a_d;
      tmp_b_q <= tmp_b_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    rd_d         = rd_q;
    rs_d         = rs_q;
    data_d       = data_q;
    gnt_d        = gnt_q;
    last_d       = last_q;
    tmp_a_d      = tmp_a_q;
    tmp_b_d      = tmp_b_q;
    win          = 1'b0;
    ack          = 1'b0;
    busy         = 1'b1;
    rf_load      = 1'b0;
    rf_addr_a    = 3'd0;
    rf_addr_b    = 3'd0;
    rf_mb_select = 1'b0;
    rf_d_in      = 8'h00;
    rf_reset_all = 1'b0;
    case (state_q)
      ST_IDLE: begin
        busy = 1'b0;
        if (c0_req || c1_req) begin
          // On contention the requester not granted last wins.
          win    = (c0_req && c1_req) ? ~last_q : c1_req;
          gnt_d  = win;
          last_d = win;
          op_d   = win ? c1_op   : c0_op;
          rd_d   = win ? c1_rd   : c0_rd;
          rs_d   = win ? c1_rs   : c0_rs;
          data_d = win ? c1_data : c0_data;
          state_d = ((win ? c1_op : c0_op) == OP_SWAP) ? ST_SW_READ : ST_EXEC;
        end
      end
      ST_EXEC: begin
        rf_load   = 1'b1;
        rf_addr_a = rd_q;
        case (op_q)
          OP_WRITE: rf_d_in = data_q;
          OP_CLEAR: rf_d_in = 8'h00;
          OP_COPY: begin
            rf_addr_b    = rs_q;
            rf_mb_select = 1'b1;
            rf_d_in      = rf_val_b;
          end
          default:  rf_d_in = 8'h00;
        endcase
        ack     = 1'b1;
        state_d = ST_IDLE;
      end
      ST_SW_READ: begin
        rf_addr_a    = rd_q;
        rf_addr_b    = rs_q;
        rf_mb_select = 1'b1;
        tmp_a_d      = rf_val_a;
        tmp_b_d      = rf_val_b;
        state_d      = ST_SW_WR_A;
      end
      ST_SW_WR_A: begin
        rf_load   = 1'b1;
        rf_addr_a = rd_q;
        rf_d_in   = tmp_b_q;
        state_d   = ST_SW_WR_B;
      end
      ST_SW_WR_B: begin
        rf_load   = 1'b1;
        rf_addr_a = rs_q;
        rf_d_in   = tmp_a_q;
        ack       = 1'b1;
        state_d   = ST_IDLE;
      end
`ifdef REGSEQ_SCRUB_EN
      ST_INIT: begin
        // Held in INIT during reset; the scrub pulse only starts once released.
        busy         = !reset;
        rf_reset_all = !reset;
        state_d      = ST_IDLE;
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  assign c0_ack = ack & ~gnt_q;
  assign c1_ack = ack &  gnt_q;

endmodule
`default_nettype wire

// File: tb/tb_regfile_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_regfile_sequencer: directed bench with a behavioural register file.   |
// | Scrub sequence compiled in with REGSEQ_SCRUB_EN.  Rev 1.0                |
// +--------------------------------------------------------------------------+
module tb_regfile_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       c0_req, c1_req, c0_ack, c1_ack;
  logic [1:0] c0_op, c1_op;
  logic [2:0] c0_rd, c0_rs, c1_rd, c1_rs;
  logic [7:0] c0_data, c1_data;
  logic       rf_load, rf_mb_select, rf_reset_all, busy;
  logic [2:0] rf_addr_a, rf_addr_b;
  logic [7:0] rf_d_in, rf_val_a, rf_val_b;

  always #5 clk = ~clk;

  regfile_sequencer dut (
    .clk(clk), .reset(reset),
    .c0_req(c0_req), .c0_op(c0_op), .c0_rd(c0_rd), .c0_rs(c0_rs), .c0_data(c0_data), .c0_ack(c0_ack),
    .c1_req(c1_req), .c1_op(c1_op), .c1_rd(c1_rd), .c1_rs(c1_rs), .c1_data(c1_data), .c1_ack(c1_ack),
    .rf_load(rf_load), .rf_addr_a(rf_addr_a), .rf_addr_b(rf_addr_b), .rf_mb_select(rf_mb_select),
    .rf_d_in(rf_d_in), .rf_reset_all(rf_reset_all), .rf_val_a(rf_val_a), .rf_val_b(rf_val_b),
    .busy(busy)
  );

  // Register file: synchronous load, asynchronous reads.
  logic [7:0] regs [8];
  always @(posedge clk) begin
    if (rf_reset_all) begin
      for (int i = 0; i < 8; i++) regs[i] <= 8'h00;
    end else if (rf_load) begin
      regs[rf_addr_a] <= rf_d_in;
    end
  end
  assign rf_val_a = regs[rf_addr_a];
  assign rf_val_b = regs[rf_addr_b];

  typedef struct {
    logic       who;
    logic [1:0] op;
    logic [2:0] rd;
    logic [2:0] rs;
    logic [7:0] data;
    int         lat;
    logic [2:0] ack_addr;
    logic [7:0] ack_din;
    logic [2:0] ca;
    logic [7:0] va;
    logic [2:0] cb;
    logic [7:0] vb;
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  vec_t vecs [11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic who, input logic req, input logic [1:0] op,
                       input logic [2:0] rd, input logic [2:0] rs, input logic [7:0] data);
    if (who) begin
      c1_req = req; c1_op = op; c1_rd = rd; c1_rs = rs; c1_data = data;
    end else begin
      c0_req = req; c0_op = op; c0_rd = rd; c0_rs = rs; c0_data = data;
    end
  endtask

  task automatic run_cmd(input vec_t v);
    int   lat;
    int   busy_n;
    logic got;
    @(negedge clk);
    check("idle_busy", busy, 0);
    drive(v.who, 1'b1, v.op, v.rd, v.rs, v.data);
    lat = 0; busy_n = 0; got = 1'b0;
    while (!got && lat < 10) begin
      @(negedge clk);
      lat++;
      if (busy) busy_n++;
      if (lat == 1) begin
        check("mb_select", rf_mb_select, v.op[1]);
        if (v.op[1]) check("addr_b", rf_addr_b, v.rs);
      end
      if (v.who ? c1_ack : c0_ack) begin
        got = 1'b1;
        check("ack_lat", lat, v.lat);
        check("busy_cycles", busy_n, v.lat);
        check("other_ack", v.who ? c0_ack : c1_ack, 0);
        check("ack_load", rf_load, 1);
        check("ack_addr_a", rf_addr_a, v.ack_addr);
        check("ack_d_in", rf_d_in, v.ack_din);
      end
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL ack_timeout: got no ack expected ack within 10 cycles");
    end
    drive(v.who, 1'b0, 2'b00, 3'd0, 3'd0, 8'h00);
    @(negedge clk);
    check("reg_a", regs[v.ca], v.va);
    check("reg_b", regs[v.cb], v.vb);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200us");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    int   n;
    reset = 1'b1;
    drive(1'b0, 1'b0, 2'b00, 3'd0, 3'd0, 8'h00);
    drive(1'b1, 1'b0, 2'b00, 3'd0, 3'd0, 8'h00);

    //          who   op     rd    rs    data   lat addr  din    ca    va     cb    vb
    vecs[0]  = '{1'b0, 2'd0, 3'd3, 3'd0, 8'hA5, 1, 3'd3, 8'hA5, 3'd3, 8'hA5, 3'd3, 8'hA5};
    vecs[1]  = '{1'b1, 2'd0, 3'd2, 3'd0, 8'h11, 1, 3'd2, 8'h11, 3'd2, 8'h11, 3'd3, 8'hA5};
    vecs[2]  = '{1'b0, 2'd0, 3'd5, 3'd0, 8'h22, 1, 3'd5, 8'h22, 3'd5, 8'h22, 3'd2, 8'h11};
    vecs[3]  = '{1'b1, 2'd3, 3'd2, 3'd5, 8'h00, 3, 3'd5, 8'h11, 3'd2, 8'h22, 3'd5, 8'h11};
    vecs[4]  = '{1'b0, 2'd0, 3'd4, 3'd0, 8'h7E, 1, 3'd4, 8'h7E, 3'd4, 8'h7E, 3'd5, 8'h11};
    vecs[5]  = '{1'b0, 2'd2, 3'd1, 3'd4, 8'h00, 1, 3'd1, 8'h7E, 3'd1, 8'h7E, 3'd4, 8'h7E};
    vecs[6]  = '{1'b0, 2'd1, 3'd4, 3'd0, 8'hFF, 1, 3'd4, 8'h00, 3'd4, 8'h00, 3'd1, 8'h7E};
    vecs[7]  = '{1'b1, 2'd3, 3'd3, 3'd3, 8'h00, 3, 3'd3, 8'hA5, 3'd3, 8'hA5, 3'd3, 8'hA5};
    vecs[8]  = '{1'b1, 2'd2, 3'd0, 3'd3, 8'h00, 1, 3'd0, 8'hA5, 3'd0, 8'hA5, 3'd3, 8'hA5};
    vecs[9]  = '{1'b0, 2'd3, 3'd0, 3'd1, 8'h00, 3, 3'd1, 8'hA5, 3'd0, 8'h7E, 3'd1, 8'hA5};
    vecs[10] = '{1'b1, 2'd0, 3'd7, 3'd0, 8'hC3, 1, 3'd7, 8'hC3, 3'd7, 8'hC3, 3'd0, 8'h7E};

    // Reset state, sampled while reset is held.
    repeat (2) @(negedge clk);
    check("rst_load", rf_load, 0);
    check("rst_addr_a", rf_addr_a, 0);
    check("rst_addr_b", rf_addr_b, 0);
    check("rst_mb_select", rf_mb_select, 0);
    check("rst_d_in", rf_d_in, 0);
    check("rst_reset_all", rf_reset_all, 0);
    check("rst_acks", {c0_ack, c1_ack}, 0);
    check("rst_busy", busy, 0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 11; i++) run_cmd(vecs[i]);

    // Continuous contention: grants must alternate starting with c0.
    do_reset();
    drive(1'b0, 1'b1, 2'd0, 3'd6, 3'd0, 8'h66);
    drive(1'b1, 1'b1, 2'd0, 3'd7, 3'd0, 8'h77);
    n = 0;
    for (int cyc = 0; cyc < 30 && n < 6; cyc++) begin
      @(negedge clk);
      if (c0_ack || c1_ack) begin
        check("grant_overlap", c0_ack & c1_ack, 0);
        check("grant_order", c1_ack, n % 2);
        n++;
      end
    end
    if (n < 6) begin
      checks++; errors++;
      $display("FAIL grant_timeout: got %0d acks expected 6", n);
    end
    drive(1'b0, 1'b0, 2'd0, 3'd0, 3'd0, 8'h00);
    drive(1'b1, 1'b0, 2'd0, 3'd0, 3'd0, 8'h00);
    @(negedge clk);
    check("contend_r6", regs[6], 8'h66);
    check("contend_r7", regs[7], 8'h77);

    // Reset landing at the end of SW_WR_A: rd updated, rs untouched, no ack.
    v = '{1'b0, 2'd0, 3'd2, 3'd0, 8'h33, 1, 3'd2, 8'h33, 3'd2, 8'h33, 3'd2, 8'h33};
    run_cmd(v);
    v = '{1'b1, 2'd0, 3'd5, 3'd0, 8'h44, 1, 3'd5, 8'h44, 3'd5, 8'h44, 3'd2, 8'h33};
    run_cmd(v);
    @(negedge clk);
    drive(1'b0, 1'b1, 2'd3, 3'd2, 3'd5, 8'h00);
    @(negedge clk);
    check("abort_read_busy", busy, 1);
    @(negedge clk);
    check("abort_wr_a_load", rf_load, 1);
    check("abort_wr_a_d_in", rf_d_in, 8'h44);
    @(posedge clk);
    reset = 1'b1;
    drive(1'b0, 1'b0, 2'd0, 3'd0, 3'd0, 8'h00);
    #1;
    check("abort_ack", c0_ack, 0);
    check("abort_load", rf_load, 0);
    check("abort_addr_a", rf_addr_a, 0);
    check("abort_d_in", rf_d_in, 0);
    check("abort_busy", busy, 0);
    @(negedge clk);
    check("abort_rd", regs[2], 8'h44);
    check("abort_rs", regs[5], 8'h44);
    reset = 1'b0;
    @(negedge clk);

`ifdef REGSEQ_SCRUB_EN
    for (int i = 0; i < 8; i++) begin
      v = '{1'b0, 2'd0, 3'(i), 3'd0, 8'(8'h10 + i), 1, 3'(i), 8'(8'h10 + i),
            3'(i), 8'(8'h10 + i), 3'(i), 8'(8'h10 + i)};
      run_cmd(v);
    end
    @(negedge clk);
    reset = 1'b1;
    drive(1'b1, 1'b1, 2'd0, 3'd7, 3'd0, 8'h5A);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("scrub_reset_all", rf_reset_all, 1);
    check("scrub_busy", busy, 1);
    @(negedge clk);
    check("scrub_idle_ack", c1_ack, 0);
    for (int i = 0; i < 8; i++) check("scrub_cleared", regs[i], 0);
    @(negedge clk);
    check("scrub_pending_ack", c1_ack, 1);
    drive(1'b1, 1'b0, 2'd0, 3'd0, 3'd0, 8'h00);
    @(negedge clk);
    check("scrub_write", regs[7], 8'h5A);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
